// File: rtl/vectored_int.sv
// Vectored interrupt source selector.
// Edge-captures four peripheral completion pulses, keeps them sticky until
// acknowledged, and drives the jump-vector address of the highest-priority
// outstanding source (done1 highest, done4 lowest).
module vectored_int #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_01F0,
    parameter logic [31:0] STRIDE    = 32'd4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        int_ack,
    input  logic        done1,
    input  logic        done2,
    input  logic        done3,
    input  logic        done4,
    output logic [31:0] int_addr,
    output logic        irq,
    output logic [1:0]  int_id
);

    logic [3:0] done_in;
    logic [3:0] done_q, done_d;
    logic [3:0] pend_q, pend_d;
    logic [3:0] rise;
    logic [3:0] req;
    logic       req_any;
    logic       lvl_any;
    logic [1:0] sel;
    logic       sel_vld;

    assign done_in = {done4, done3, done2, done1};

    // Edge detect and request merge; a rise is visible in the same cycle so
    // the controller can acknowledge it without waiting for the register.
    always_comb begin
        rise    = done_in & ~done_q;
        req     = pend_q | rise;
        req_any = |req;
        lvl_any = |done_in;
    end

    // Fixed-priority select: pending/edge requests first, raw levels as fallback.
    always_comb begin
        sel     = 2'd0;
        sel_vld = 1'b0;
        if (req_any) begin
            sel_vld = 1'b1;
            if      (req[0]) sel = 2'd0;
            else if (req[1]) sel = 2'd1;
            else if (req[2]) sel = 2'd2;
            else             sel = 2'd3;
        end else if (lvl_any) begin
            sel_vld = 1'b1;
            if      (done_in[0]) sel = 2'd0;
            else if (done_in[1]) sel = 2'd1;
            else if (done_in[2]) sel = 2'd2;
            else                 sel = 2'd3;
        end
    end

    // Vector address and status outputs; idle drives all zeros.
    always_comb begin
        int_addr = 32'h0;
        int_id   = 2'd0;
        irq      = req_any | lvl_any;
        if (sel_vld) begin
            int_addr = BASE_ADDR + STRIDE * {30'd0, sel};
            int_id   = sel;
        end
    end

    // Next state: ack consumes only the selected request, and only when it
    // came from a pending/edge request (a level-fallback ack clears nothing).
    always_comb begin
        done_d = done_in;
        pend_d = req;
        if (int_ack && req_any) begin
            pend_d[sel] = 1'b0;
        end
    end

    // State registers with synchronous reset; reset beats a concurrent ack.
    always_ff @(posedge clk) begin
        if (reset) begin
            done_q <= 4'd0;
            pend_q <= 4'd0;
        end else begin
            done_q <= done_d;
            pend_q <= pend_d;
        end
    end

endmodule

// File: tb/tb_vectored_int.sv
// Directed bench for vectored_int: hand-computed vectors applied in sequence.
module tb_vectored_int;

    logic        clk;
    logic        reset;
    logic        int_ack;
    logic        done1, done2, done3, done4;
    logic [31:0] int_addr;
    logic        irq;
    logic [1:0]  int_id;

    int vectors;
    int miscompares;

    vectored_int dut (
        .clk      (clk),
        .reset    (reset),
        .int_ack  (int_ack),
        .done1    (done1),
        .done2    (done2),
        .done3    (done3),
        .done4    (done4),
        .int_addr (int_addr),
        .irq      (irq),
        .int_id   (int_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past the next rising edge; inputs are then changed mid-cycle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle, then compare all three outputs.
    task automatic chk(input string tag, input logic [31:0] exp_addr,
                       input logic exp_irq, input logic [1:0] exp_id);
        #1;
        vectors++;
        assert (int_addr === exp_addr) else begin
            miscompares++;
            $error("FAIL %s int_addr: got %h expected %h", tag, int_addr, exp_addr);
        end
        vectors++;
        assert (irq === exp_irq) else begin
            miscompares++;
            $error("FAIL %s irq: got %b expected %b", tag, irq, exp_irq);
        end
        vectors++;
        assert (int_id === exp_id) else begin
            miscompares++;
            $error("FAIL %s int_id: got %0d expected %0d", tag, int_id, exp_id);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset   = 1'b1;
        int_ack = 1'b0;
        done1 = 1'b0; done2 = 1'b0; done3 = 1'b0; done4 = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        // 1: idle after reset
        chk("reset_idle", 32'h0, 1'b0, 2'd0);

        // 2: done2 single-cycle pulse, stays pending until acked
        done2 = 1'b1;
        chk("d2_rise", 32'h1F4, 1'b1, 2'd1);
        tick();
        done2 = 1'b0;
        chk("d2_pend1", 32'h1F4, 1'b1, 2'd1);
        tick();
        chk("d2_pend2", 32'h1F4, 1'b1, 2'd1);
        int_ack = 1'b1;
        chk("d2_ack", 32'h1F4, 1'b1, 2'd1);
        tick();
        int_ack = 1'b0;
        chk("d2_cleared", 32'h0, 1'b0, 2'd0);

        // 3: done1 and done3 together, served in priority order
        done1 = 1'b1; done3 = 1'b1;
        chk("d13_rise", 32'h1F0, 1'b1, 2'd0);
        tick();
        done1 = 1'b0; done3 = 1'b0;
        chk("d13_pend", 32'h1F0, 1'b1, 2'd0);
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        chk("d13_after_ack1", 32'h1F8, 1'b1, 2'd2);
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        chk("d13_after_ack2", 32'h0, 1'b0, 2'd0);

        // 4: done4 rise consumed by same-cycle ack; held level falls back
        done4 = 1'b1; int_ack = 1'b1;
        chk("d4_rise_ack", 32'h1FC, 1'b1, 2'd3);
        tick();
        int_ack = 1'b0;
        chk("d4_level", 32'h1FC, 1'b1, 2'd3);
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        chk("d4_level_after_ack", 32'h1FC, 1'b1, 2'd3);
        tick();
        chk("d4_held_no_new_event", 32'h1FC, 1'b1, 2'd3);
        done4 = 1'b0;
        chk("d4_released", 32'h0, 1'b0, 2'd0);
        tick();

        // 5: done3 pending, done1 rises in the ack cycle and wins the ack
        done3 = 1'b1;
        chk("d3_rise", 32'h1F8, 1'b1, 2'd2);
        tick();
        done3 = 1'b0;
        chk("d3_pend", 32'h1F8, 1'b1, 2'd2);
        done1 = 1'b1; int_ack = 1'b1;
        chk("d1_rise_during_ack", 32'h1F0, 1'b1, 2'd0);
        tick();
        int_ack = 1'b0;
        chk("d3_still_pend", 32'h1F8, 1'b1, 2'd2);
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        chk("d3_cleared_d1_level", 32'h1F0, 1'b1, 2'd0);
        done1 = 1'b0;
        chk("d5_idle", 32'h0, 1'b0, 2'd0);
        tick();

        // All four rising at once: done1 wins
        done1 = 1'b1; done2 = 1'b1; done3 = 1'b1; done4 = 1'b1;
        chk("all_rise", 32'h1F0, 1'b1, 2'd0);
        tick();
        done1 = 1'b0; done2 = 1'b0; done3 = 1'b0; done4 = 1'b0;
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        chk("all_after_ack", 32'h1F4, 1'b1, 2'd1);

        // 6: reset together with ack drops everything pending
        reset = 1'b1; int_ack = 1'b1;
        tick();
        reset = 1'b0; int_ack = 1'b0;
        chk("reset_with_ack", 32'h0, 1'b0, 2'd0);
        done2 = 1'b1;
        tick();
        done2 = 1'b0;
        chk("d2_pend_pre_reset", 32'h1F4, 1'b1, 2'd1);
        reset = 1'b1; int_ack = 1'b1;
        tick();
        reset = 1'b0; int_ack = 1'b0;
        chk("d2_reset_cleared", 32'h0, 1'b0, 2'd0);
        tick();
        chk("final_idle", 32'h0, 1'b0, 2'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
